blink_timer: RTL

BLINK_TIMER -- requirements
Module: blink_timer

---
 rtl/blink_timer.sv | 86 ++++++++
 1 files changed

// File: rtl/blink_timer.sv
// LED blink timer: a down-counter that reloads from load_val on expiry, pulsing tick and toggling blink.
// Optional step prescaler enabled by defining BLINK_PRESCALE_EN (PRESCALE en cycles per step).
module blink_timer #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             blink
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic             blink_q, blink_d;
  logic             step;

`ifdef BLINK_PRESCALE_EN
  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pre_q, pre_d;
  logic          pre_wrap;

  assign pre_wrap = (pre_q == PW'(PRESCALE - 1));
  assign step     = en && pre_wrap;

  // Restart realigns the step phase so a fresh period is a full period long.
  always_comb begin
    pre_d = pre_q;
    if (restart) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = pre_wrap ? '0 : pre_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end
`else
  assign step = en;
`endif

  always_comb begin
    count_d = count_q;
    tick_d  = 1'b0;
    blink_d = blink_q;
    // Restart wins over a coincident expiry: reload without tick or toggle.
    if (restart) begin
      count_d = load_val;
    end else if (step) begin
      if (count_q == '0) begin
        count_d = load_val;
        tick_d  = 1'b1;
        blink_d = ~blink_q;
      end else begin
        count_d = count_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      tick_q  <= 1'b0;
      blink_q <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
      blink_q <= blink_d;
    end
  end

  assign count = count_q;
  assign tick  = tick_q;
  assign blink = blink_q;

endmodule
